// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, parity modes and parity helper
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_START  = 3'd2,
      ST_DATA   = 3'd3,
      ST_PARITY = 3'd4,
      ST_STOP   = 3'd5
   } uart_state_t;

   localparam logic PARITY_EVEN = 1'b0;
   localparam logic PARITY_ODD  = 1'b1;
   localparam int   MAX_WIDTH   = 8;

   // Narrower frames are zero-extended, which leaves the XOR unchanged.
   function automatic logic parity_bit(input logic [MAX_WIDTH-1:0] data, input logic mode);
      return (^data) ^ (mode == PARITY_ODD);
   endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - per-bit clock divider with load, enable and bit_end strobe
module uart_baud_cnt #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             enable,
   input  logic [DIV_W-1:0] div,
   output logic             bit_end
);

   logic [DIV_W-1:0] term;
   logic [DIV_W-1:0] cnt;

   // Terminal count is D-1 with D = max(div,1), so cnt never exceeds 2^DIV_W-2.
   always_ff @(posedge clk) begin
      if (rst) begin
         term <= '0;
         cnt  <= '0;
      end else if (load) begin
         term <= (div > DIV_W'(1)) ? div - DIV_W'(1) : '0;
         cnt  <= '0;
      end else if (enable) begin
         cnt <= bit_end ? '0 : cnt + DIV_W'(1);
      end
   end

   assign bit_end = enable && (cnt == term);

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - FIFO-fed UART transmitter with optional parity and two stop bits
module uart_tx
   import uart_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DIV_W-1:0] baud_div,
   input  logic             parity_en,
   input  logic             parity_odd,
   input  logic             stop2,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_r_data,
   output logic             fifo_r_request,
   output logic             tx,
   output logic             busy,
   output logic             tx_done
);

   localparam int BIT_W = $clog2(WIDTH) + 1;

   uart_state_t      state;
   uart_state_t      state_d;
   logic [WIDTH-1:0] shift_q;
   logic [WIDTH-1:0] shift_d;
   logic [BIT_W-1:0] bit_cnt;
   logic             parity_en_q;
   logic             stop2_q;
   logic             parity_q;
   logic             stop_half;
   logic             tx_d;
   logic             bit_end;
   logic             baud_load;
   logic             baud_en;
   logic             last_data;
   logic             stop_last;

   assign baud_load = (state == ST_FETCH);
   assign baud_en   = (state == ST_START) || (state == ST_DATA) ||
                      (state == ST_PARITY) || (state == ST_STOP);
   assign last_data = (bit_cnt == BIT_W'(WIDTH - 1));
   assign stop_last = bit_end && (!stop2_q || stop_half);

   uart_baud_cnt #(.DIV_W(DIV_W)) u_baud (
      .clk     (clk),
      .rst     (rst),
      .load    (baud_load),
      .enable  (baud_en),
      .div     (baud_div),
      .bit_end (bit_end)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         ST_IDLE:   if (!fifo_empty) state_d = ST_FETCH;
         ST_FETCH:  state_d = ST_START;
         ST_START:  if (bit_end) state_d = ST_DATA;
         ST_DATA:   if (bit_end && last_data) state_d = parity_en_q ? ST_PARITY : ST_STOP;
         ST_PARITY: if (bit_end) state_d = ST_STOP;
         ST_STOP:   if (stop_last) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // tx is registered, so its next value is derived from the next state.
   always_comb begin
      fifo_r_request = (state == ST_IDLE) && !fifo_empty && !rst;
      busy           = (state != ST_IDLE);
      tx_done        = (state == ST_STOP) && stop_last;
      shift_d        = shift_q;
      if (state == ST_FETCH) shift_d = fifo_r_data;
      else if (state == ST_DATA && bit_end) shift_d = shift_q >> 1;
      case (state_d)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = shift_d[0];
         ST_PARITY: tx_d = parity_q;
         default:   tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx      <= 1'b1;
         shift_q <= '0;
      end else begin
         tx      <= tx_d;
         shift_q <= shift_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         parity_en_q <= 1'b0;
         stop2_q     <= 1'b0;
         parity_q    <= 1'b0;
      end else if (state == ST_FETCH) begin
         parity_en_q <= parity_en;
         stop2_q     <= stop2;
         parity_q    <= parity_bit(MAX_WIDTH'(fifo_r_data), parity_odd);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt   <= '0;
         stop_half <= 1'b0;
      end else if (state == ST_FETCH) begin
         bit_cnt   <= '0;
         stop_half <= 1'b0;
      end else begin
         if (state == ST_DATA && bit_end) bit_cnt <= bit_cnt + BIT_W'(1);
         if (state == ST_STOP && bit_end) stop_half <= ~stop_half;
      end
   end

endmodule
